// File: rtl/sata_fis_pkg.sv
// Shared FIS definitions for the host-side receive path.
package sata_fis_pkg;

  // FIS type codes (byte 0 of the header word)
  localparam logic [7:0] FisTypeRegH2D = 8'h27;
  localparam logic [7:0] FisTypeRegD2H = 8'h34;
  localparam logic [7:0] FisTypeDmaAct = 8'h39;
  localparam logic [7:0] FisTypeData   = 8'h46;

  // ATA status register bit positions
  localparam int unsigned StatusErr  = 0;
  localparam int unsigned StatusDrq  = 3;
  localparam int unsigned StatusDf   = 5;
  localparam int unsigned StatusDrdy = 6;
  localparam int unsigned StatusBsy  = 7;

  // Receive parser states
  typedef enum logic [1:0] {
    StIdle,
    StReg,
    StData,
    StDrop
  } parse_state_e;

endpackage

// File: rtl/satarsp_watchdog.sv
// Command-response watchdog: armed by start, disarmed by a completed response,
// fires a single-cycle timeout when no word is accepted for TIMEOUT_CYCLES cycles.
module satarsp_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic activity_i,
  input  logic done_i,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  // Registered pulse lands as the count reaches TIMEOUT_CYCLES-1, so decide one step early.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);

  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state: start beats both completion and timeout
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (done_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (activity_i) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        timeout_d = 1'b1;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/satarsp_parse.sv
// Host receive parser for device-to-host FIS words: classifies frames, captures
// D2H Register fields, forwards Data FIS payload and flags malformed frames.
module satarsp_parse #(
  parameter int unsigned D2H_LEN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        i_cmd_start,
  output logic        o_busy,
  output logic        o_d2h_valid,
  output logic [7:0]  o_status,
  output logic [7:0]  o_error,
  output logic [7:0]  o_device,
  output logic [47:0] o_lba,
  output logic [15:0] o_count,
  output logic        o_dma_act,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        o_frame_err,
  output logic        o_timeout
);

  import sata_fis_pkg::*;

  localparam logic [2:0] IdxLast = 3'(D2H_LEN - 1);

  parse_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   sh_status_q, sh_status_d, sh_error_q, sh_error_d, sh_device_q, sh_device_d;
  logic [47:0]  sh_lba_q, sh_lba_d;
  logic [15:0]  sh_count_q, sh_count_d;
  logic         frame_err_d, dma_act_d, d2h_done;
  logic         s_acc;

  // Handshake: payload passes straight through in DATA, everything else is always accepted
  always_comb begin
    s_ready = (state_q == StData) ? m_ready : 1'b1;
    m_valid = (state_q == StData) && s_valid;
    m_last  = (state_q == StData) && s_last;
    m_data  = s_data;
    s_acc   = s_valid && s_ready;
  end

  // Next-state and shadow capture, acting only on accepted words
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_status_d = sh_status_q;
    sh_error_d  = sh_error_q;
    sh_device_d = sh_device_q;
    sh_lba_d    = sh_lba_q;
    sh_count_d  = sh_count_q;
    frame_err_d = 1'b0;
    dma_act_d   = 1'b0;
    d2h_done    = 1'b0;
    if (s_acc) begin
      unique case (state_q)
        StIdle: begin
          case (s_data[31:24])
            FisTypeRegD2H: begin
              if (s_last) begin
                frame_err_d = 1'b1;
              end else begin
                sh_status_d = s_data[15:8];
                sh_error_d  = s_data[7:0];
                idx_d       = 3'd1;
                state_d     = StReg;
              end
            end
            FisTypeDmaAct: begin
              if (s_last) begin
                dma_act_d = 1'b1;
              end else begin
                frame_err_d = 1'b1;
                state_d     = StDrop;
              end
            end
            FisTypeData: begin
              if (s_last) frame_err_d = 1'b1;
              else        state_d     = StData;
            end
            default: begin
              frame_err_d = 1'b1;
              if (!s_last) state_d = StDrop;
            end
          endcase
        end
        StReg: begin
          case (idx_q)
            3'd1: begin
              sh_device_d     = s_data[31:24];
              sh_lba_d[23:0]  = s_data[23:0];
            end
            3'd2:    sh_lba_d[47:24] = s_data[23:0];
            3'd3:    sh_count_d      = s_data[15:0];
            default: ;
          endcase
          idx_d = idx_q + 3'd1;
          if (s_last) begin
            state_d = StIdle;
            if (idx_q == IdxLast) d2h_done    = 1'b1;
            else                  frame_err_d = 1'b1;
          end else if (idx_q == IdxLast) begin
            frame_err_d = 1'b1;
            state_d     = StDrop;
          end
        end
        StData: if (s_last) state_d = StIdle;
        StDrop: if (s_last) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State, shadows, pulses and committed fields
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      sh_status_q <= 8'h00;
      sh_error_q  <= 8'h00;
      sh_device_q <= 8'h00;
      sh_lba_q    <= 48'h0;
      sh_count_q  <= 16'h0;
      o_d2h_valid <= 1'b0;
      o_dma_act   <= 1'b0;
      o_frame_err <= 1'b0;
      o_status    <= 8'h00;
      o_error     <= 8'h00;
      o_device    <= 8'h00;
      o_lba       <= 48'h0;
      o_count     <= 16'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_status_q <= sh_status_d;
      sh_error_q  <= sh_error_d;
      sh_device_q <= sh_device_d;
      sh_lba_q    <= sh_lba_d;
      sh_count_q  <= sh_count_d;
      o_d2h_valid <= d2h_done;
      o_dma_act   <= dma_act_d;
      o_frame_err <= frame_err_d;
      // Commit from the next-state shadows so the closing word is included
      if (d2h_done) begin
        o_status <= sh_status_d;
        o_error  <= sh_error_d;
        o_device <= sh_device_d;
        o_lba    <= sh_lba_d;
        o_count  <= sh_count_d;
      end
    end
  end

  satarsp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .start_i   (i_cmd_start),
    .activity_i(s_acc),
    .done_i    (d2h_done),
    .busy_o    (o_busy),
    .timeout_o (o_timeout)
  );

endmodule

// File: tb/tb_satarsp_parse.sv
// Scoreboard bench for satarsp_parse: frame-level reference model pushes expected
// events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_satarsp_parse;

  localparam int unsigned D2H_LEN = 4;
  localparam int unsigned TMO     = 16;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        i_cmd_start = 1'b0;
  logic        o_busy, o_d2h_valid, o_dma_act, o_frame_err, o_timeout;
  logic [7:0]  o_status, o_error, o_device;
  logic [47:0] o_lba;
  logic [15:0] o_count;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;

  satarsp_parse #(
    .D2H_LEN       (D2H_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .i_cmd_start(i_cmd_start),
    .o_busy     (o_busy),
    .o_d2h_valid(o_d2h_valid),
    .o_status   (o_status),
    .o_error    (o_error),
    .o_device   (o_device),
    .o_lba      (o_lba),
    .o_count    (o_count),
    .o_dma_act  (o_dma_act),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .o_frame_err(o_frame_err),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  st, er, dev;
    logic [47:0] lba;
    logic [15:0] cnt;
  } d2h_t;

  d2h_t        q_d2h[$];
  int          q_dma[$], q_ferr[$], q_tmo[$];
  logic [32:0] q_beat[$];
  d2h_t        mdl;
  logic [31:0] frm[$];
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Sink backpressure: 0 = always ready, 1 = toggle, 2 = random
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  d2h_t        mon_e;
  int          mon_c;
  logic [32:0] mon_b;
  always @(negedge i_clk) begin
    if (o_d2h_valid) begin
      if (q_d2h.size() == 0) unexpected("d2h_valid");
      else begin
        mon_e = q_d2h.pop_front();
        chk("d2h_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("d2h_status", 64'(o_status), 64'(mon_e.st));
        chk("d2h_error", 64'(o_error), 64'(mon_e.er));
        chk("d2h_device", 64'(o_device), 64'(mon_e.dev));
        chk("d2h_lba", 64'(o_lba), 64'(mon_e.lba));
        chk("d2h_count", 64'(o_count), 64'(mon_e.cnt));
      end
    end
    if (o_dma_act) begin
      if (q_dma.size() == 0) unexpected("dma_act");
      else begin mon_c = q_dma.pop_front(); chk("dma_cycle", 64'(cyc), 64'(mon_c)); end
    end
    if (o_frame_err) begin
      if (q_ferr.size() == 0) unexpected("frame_err");
      else begin mon_c = q_ferr.pop_front(); chk("ferr_cycle", 64'(cyc), 64'(mon_c)); end
    end
    if (o_timeout) begin
      if (q_tmo.size() == 0) unexpected("timeout");
      else begin mon_c = q_tmo.pop_front(); chk("timeout_cycle", 64'(cyc), 64'(mon_c)); end
    end
    if (m_valid && m_ready) begin
      if (q_beat.size() == 0) unexpected("m_beat");
      else begin
        mon_b = q_beat.pop_front();
        chk("m_data", 64'(m_data), 64'(mon_b[31:0]));
        chk("m_last", 64'(m_last), 64'(mon_b[32]));
      end
    end
  end

  // Presents one word; returns the cycle number of the accepting edge.
  // Entered and left #1 after a rising edge.
  task automatic send_word(input logic [31:0] w, input logic last, output int acc);
    acc     = -1;
    s_valid = 1'b1;
    s_data  = w;
    s_last  = last;
    for (int b = 0; b < 200; b++) begin
      @(negedge i_clk);
      if (s_ready) begin
        acc = cyc + 1;
        @(posedge i_clk);
        #1;
        break;
      end
      @(posedge i_clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
    if (acc < 0) unexpected("accept_stall");
  endtask

  // Frame-level reference: outcome depends only on type byte, length and position
  task automatic run_frame(input bit gaps);
    int         n, acc;
    logic [7:0] typ;
    d2h_t       e;
    bit         last;
    n   = frm.size();
    typ = frm[0][31:24];
    for (int p = 0; p < n; p++) begin
      last = (p == n - 1);
      if (typ == 8'h46 && p > 0) q_beat.push_back({last, frm[p]});
      send_word(frm[p], last, acc);
      case (typ)
        8'h34: begin
          if (n == D2H_LEN && last) begin
            e.cyc = acc;
            e.st  = frm[0][15:8];
            e.er  = frm[0][7:0];
            e.dev = frm[1][31:24];
            e.lba = {frm[2][23:0], frm[1][23:0]};
            e.cnt = frm[3][15:0];
            q_d2h.push_back(e);
            mdl = e;
          end else if (n < D2H_LEN && last) begin
            q_ferr.push_back(acc);
          end else if (n > D2H_LEN && p == D2H_LEN - 1) begin
            q_ferr.push_back(acc);
          end
        end
        8'h39:   if (p == 0) begin
                   if (n == 1) q_dma.push_back(acc);
                   else        q_ferr.push_back(acc);
                 end
        8'h46:   if (p == 0 && n == 1) q_ferr.push_back(acc);
        default: if (p == 0) q_ferr.push_back(acc);
      endcase
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge i_clk); #1; end
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge i_clk); #1; end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_status"}, 64'(o_status), 64'(mdl.st));
    chk({tag, "_error"}, 64'(o_error), 64'(mdl.er));
    chk({tag, "_device"}, 64'(o_device), 64'(mdl.dev));
    chk({tag, "_lba"}, 64'(o_lba), 64'(mdl.lba));
    chk({tag, "_count"}, 64'(o_count), 64'(mdl.cnt));
  endtask

  task automatic do_start(output int e);
    i_cmd_start = 1'b1;
    @(negedge i_clk);
    e = cyc + 1;
    @(posedge i_clk);
    #1;
    i_cmd_start = 1'b0;
  endtask

  task automatic good_d2h();
    logic [31:0] w;
    frm.delete();
    w = $urandom; w[31:24] = 8'h34; frm.push_back(w);
    for (int i = 1; i < D2H_LEN; i++) frm.push_back($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int e1, e2, k, n, acc;
    logic [31:0] w;
    logic [7:0]  t;

    mdl = '{cyc: 0, st: 8'h0, er: 8'h0, dev: 8'h0, lba: 48'h0, cnt: 16'h0};
    idle(3);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_pulses", 64'({o_d2h_valid, o_dma_act, o_frame_err, o_timeout}), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    check_held("rst");
    i_reset_n = 1'b1;
    idle(2);

    // Directed D2H Register FIS
    frm = '{32'h34007700, 32'h40123456, 32'h00000000, 32'h00000008};
    run_frame(0);
    chk("tp_status", 64'(o_status), 64'h77);
    chk("tp_error", 64'(o_error), 64'h00);
    chk("tp_device", 64'(o_device), 64'h40);
    chk("tp_lba", 64'(o_lba), 64'h000000123456);
    chk("tp_count", 64'(o_count), 64'h0008);
    idle(2);

    // DMA Activate
    frm = '{32'h39000000};
    run_frame(0);
    idle(2);

    // Data FIS with toggling sink
    rdy_mode = 1;
    frm.delete();
    frm.push_back(32'h46000000);
    for (int i = 0; i < 4; i++) frm.push_back($urandom);
    run_frame(0);
    idle(2);
    chk("data_beats_left", 64'(q_beat.size()), 64'd0);
    rdy_mode = 0;

    // Overlong D2H, then unknown type with last
    frm = '{32'h34AB0102, 32'h11111111, 32'h22222222, 32'h33333333,
            32'h44444444, 32'h55555555, 32'h66666666};
    run_frame(0);
    idle(2);
    check_held("overlong");
    frm = '{32'h55000000};
    run_frame(0);
    idle(2);
    check_held("badtype");

    // Timeout from an idle start
    do_start(e1);
    chk("busy_after_start", 64'(o_busy), 64'd1);
    q_tmo.push_back(e1 + TMO - 1);
    idle(TMO + 3);
    chk("busy_after_timeout", 64'(o_busy), 64'd0);
    chk("timeout_pending", 64'(q_tmo.size()), 64'd0);

    // Restart at cycle 10 postpones the timeout
    do_start(e1);
    idle(9);
    do_start(e2);
    q_tmo.push_back(e2 + TMO - 1);
    idle(TMO + 3);
    chk("busy_after_restart_tmo", 64'(o_busy), 64'd0);
    chk("restart_tmo_pending", 64'(q_tmo.size()), 64'd0);

    // Completion disarms the watchdog
    do_start(e1);
    good_d2h();
    run_frame(0);
    chk("busy_after_d2h", 64'(o_busy), 64'd0);
    idle(TMO + 2);

    // Randomized traffic
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      k = $urandom_range(0, 7);
      frm.delete();
      case (k)
        0, 1: good_d2h();
        2, 3: begin
          n = (k == 2) ? $urandom_range(1, D2H_LEN - 1) : $urandom_range(D2H_LEN + 1, 7);
          w = $urandom; w[31:24] = 8'h34; frm.push_back(w);
          for (int i = 1; i < n; i++) frm.push_back($urandom);
        end
        4: begin
          n = ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(2, 3);
          w = $urandom; w[31:24] = 8'h39; frm.push_back(w);
          for (int i = 1; i < n; i++) frm.push_back($urandom);
        end
        5, 6: begin
          n = $urandom_range(1, 6);
          w = $urandom; w[31:24] = 8'h46; frm.push_back(w);
          for (int i = 1; i < n; i++) frm.push_back($urandom);
        end
        default: begin
          do t = 8'($urandom_range(0, 255));
          while (t == 8'h34 || t == 8'h39 || t == 8'h46);
          n = $urandom_range(1, 3);
          w = $urandom; w[31:24] = t; frm.push_back(w);
          for (int i = 1; i < n; i++) frm.push_back($urandom);
        end
      endcase
      run_frame(1);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(3);
    check_held("random");
    rdy_mode = 0;

    // Reset in the middle of a D2H frame
    good_d2h();
    run_frame(0);
    send_word(32'h34112233, 1'b0, acc);
    send_word($urandom, 1'b0, acc);
    i_reset_n = 1'b0;
    #1;
    mdl = '{cyc: 0, st: 8'h0, er: 8'h0, dev: 8'h0, lba: 48'h0, cnt: 16'h0};
    check_held("midreset");
    chk("midreset_busy", 64'(o_busy), 64'd0);
    chk("midreset_pulses", 64'({o_d2h_valid, o_dma_act, o_frame_err, o_timeout, m_valid}),
        64'd0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    idle(1);
    good_d2h();
    run_frame(0);
    idle(2);
    check_held("after_reset");

    chk("pending_d2h", 64'(q_d2h.size()), 64'd0);
    chk("pending_dma", 64'(q_dma.size()), 64'd0);
    chk("pending_ferr", 64'(q_ferr.size()), 64'd0);
    chk("pending_tmo", 64'(q_tmo.size()), 64'd0);
    chk("pending_beat", 64'(q_beat.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
